// File: rtl/riscv_dbg_pkg.sv
// Shared types and constants for the register-file debug dump.
package riscv_dbg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LOAD,
    IDX,
    DATA,
    CSUM
  } dump_state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         BYTES_PER_REG     = 4;

endpackage

// File: rtl/riscv_word_serializer.sv
// Holds one captured register word and presents it MSB byte first.
// The byte at the top of the shift register is always on byte_out; the
// owner advances it after each accepted byte and reads last_out to know
// when the word is exhausted.
module riscv_word_serializer
  import riscv_dbg_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        load_in,
  input  logic [31:0] word_in,
  input  logic        adv_in,
  output logic [7:0]  byte_out,
  output logic        last_out
);

  localparam int CW = $clog2(BYTES_PER_REG);

  logic [31:0]   shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Load restarts the byte count; advance shifts the next byte into view.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (load_in) begin
      shift_d = word_in;
      cnt_d   = '0;
    end else if (adv_in) begin
      shift_d = {shift_q[23:0], 8'h00};
      cnt_d   = cnt_q + 1'b1;
    end
  end

  // Word and byte-count registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign byte_out = shift_q[31:24];
  assign last_out = (cnt_q == CW'(BYTES_PER_REG - 1));

endmodule

// File: rtl/riscv_regdump.sv
// Post-halt register dump: walks the register file debug port and streams
// a framed byte dump (sync, per-register index + value, XOR checksum).
//
// state | meaning
// IDLE  | waiting for start; index and checksum held at their initial values
// HDR   | presenting the sync byte
// LOAD  | bubble cycle: value of the current index captured into the serializer
// IDX   | presenting the index byte of the current register
// DATA  | presenting the four value bytes, MSB first
// CSUM  | presenting the checksum byte; done pulses after it is accepted
module riscv_regdump
  import riscv_dbg_pkg::*;
#(
  parameter int         NUM_REGS  = 32,
  parameter int         FIRST_REG = 0,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        start_in,
  input  logic        abort_in,
  output logic [4:0]  reg_debug_out,
  input  logic [31:0] reg_debug_in,
  output logic [7:0]  byte_out,
  output logic        byte_valid_out,
  input  logic        byte_ready_in,
  output logic        busy_out,
  output logic        done_out
);

  localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
  localparam logic [4:0] LAST_IDX  = 5'(NUM_REGS - 1);

  dump_state_t state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [7:0]  csum_q, csum_d;
  logic        done_q, done_d;

  logic        accept;
  logic        ser_load;
  logic        ser_adv;
  logic [7:0]  ser_byte;
  logic        ser_last;

  riscv_word_serializer u_ser (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .load_in  (ser_load),
    .word_in  (reg_debug_in),
    .adv_in   (ser_adv),
    .byte_out (ser_byte),
    .last_out (ser_last)
  );

  // Output byte selection, then next-state; abort overrides any accept.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    csum_d         = csum_q;
    done_d         = 1'b0;
    ser_load       = 1'b0;
    ser_adv        = 1'b0;
    byte_valid_out = 1'b0;
    byte_out       = 8'h00;

    case (state_q)
      HDR:  begin byte_valid_out = 1'b1; byte_out = SYNC_BYTE;        end
      IDX:  begin byte_valid_out = 1'b1; byte_out = {3'b000, idx_q};  end
      DATA: begin byte_valid_out = 1'b1; byte_out = ser_byte;         end
      CSUM: begin byte_valid_out = 1'b1; byte_out = csum_q;           end
      default: ;
    endcase

    accept = byte_valid_out && byte_ready_in && !abort_in;

    case (state_q)
      IDLE: begin
        idx_d  = FIRST_IDX;
        csum_d = 8'h00;
        if (start_in) state_d = HDR;
      end
      HDR: if (accept) state_d = LOAD;
      LOAD: begin
        ser_load = 1'b1;
        state_d  = IDX;
      end
      IDX: if (accept) begin
        csum_d  = csum_q ^ byte_out;
        state_d = DATA;
      end
      DATA: if (accept) begin
        csum_d  = csum_q ^ byte_out;
        ser_adv = 1'b1;
        if (ser_last) begin
          if (idx_q == LAST_IDX) begin
            state_d = CSUM;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = LOAD;
          end
        end
      end
      CSUM: if (accept) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && abort_in) state_d = IDLE;
  end

  // State, index, checksum and done-pulse registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      idx_q   <= 5'd0;
      csum_q  <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      done_q  <= done_d;
    end
  end

  assign reg_debug_out = (state_q == IDLE) ? 5'd0 : idx_q;
  assign busy_out      = (state_q != IDLE);
  assign done_out      = done_q;

endmodule

// File: doc/riscv_regdump.md
Name: riscv_regdump

Overview:
- Debug reader for the RISC-V register file.
- On a start pulse, walks registers FIRST_REG..NUM_REGS-1 through the register file's debug read port: drives the index, samples the returned 32-bit value.
- Streams a framed byte dump over a valid/ready byte interface to the board's UART transmitter.
- Sits beside the core in the top level. Used for post-halt state inspection.

Parameters:
- NUM_REGS, 32, registers dumped; index range 0..NUM_REGS-1; max 32.
- FIRST_REG, 0, first index dumped; must be < NUM_REGS.
- SYNC_BYTE, 8'hA5, frame header byte.

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  asynchronous active-low reset.
- start_in  input  1  request a dump; sampled only in IDLE.
- abort_in  input  1  cancel an in-progress dump.
- reg_debug_out  output  5  register index to the register file debug port.
- reg_debug_in  input  32  register value (combinational from reg_debug_out).
- byte_out  output  8  stream byte.
- byte_valid_out  output  1  byte_out valid.
- byte_ready_in  input  1  sink accepts byte this cycle.
- busy_out  output  1  high in any state other than IDLE.
- done_out  output  1  one-cycle pulse when the checksum byte is accepted.

Behaviour:
- Reset is asynchronous and active-low.
- While rst_n_in is low, all of these are 0:
  - byte_out, byte_valid_out, busy_out, done_out, reg_debug_out, internal checksum.
  - State is IDLE.
- Frame format, in order:
  - SYNC_BYTE.
  - Per register: index byte {3'b0, idx}, then value bytes MSB first ([31:24], [23:16], [15:8], [7:0]).
  - Checksum byte: XOR of every byte after SYNC_BYTE.
- Frame length is 2 + 5*(NUM_REGS-FIRST_REG) bytes; 162 with defaults.
- States: IDLE, HDR, LOAD, IDX, DATA, CSUM.
- IDLE:
  - start_in high at an edge -> HDR.
  - Index counter := FIRST_REG.
  - Checksum := 0.
- HDR:
  - byte_valid_out = 1, byte_out = SYNC_BYTE.
  - On accept -> LOAD.
- LOAD:
  - One cycle, byte_valid_out = 0.
  - reg_debug_in captured into a 32-bit shift register -> IDX.
  - reg_debug_out equals the index counter at all times outside IDLE.
- IDX:
  - Drives the index byte.
  - On accept: checksum ^= byte -> DATA, byte counter := 0.
- DATA:
  - Drives shift[31:24].
  - On accept: checksum ^= byte, shift <<= 8, byte counter += 1.
  - After the 4th accept:
    - If index == NUM_REGS-1 -> CSUM.
    - Else index += 1 -> LOAD.
- CSUM:
  - Drives the checksum byte.
  - On accept: done_out pulses for 1 cycle -> IDLE.
- Handshake:
  - A byte transfers on an edge with byte_valid_out && byte_ready_in.
  - While valid && !ready, byte_out and byte_valid_out stay stable; valid is never withdrawn except by abort or reset.
  - Throughput is one byte per cycle within a register.
  - There is exactly one bubble cycle (LOAD) per register.
- Latency: with ready held high, start at edge k gives SYNC_BYTE valid from edge k+1, and the first index byte valid from edge k+3.
- Register values are sampled once in LOAD. Later register file writes do not affect bytes already captured.
- start_in while busy is ignored. No queuing.
- abort_in, sampled at an edge in any non-IDLE state:
  - Next state IDLE, byte_valid_out := 0.
  - No done_out.
  - Takes priority over a simultaneous accept.
- done_out and abort never coincide.
- The index counter is 5 bits and never wraps past NUM_REGS-1. The last index is NUM_REGS-1.
- Async reset mid-frame: outputs drop immediately. After release, the block returns to IDLE and sends no partial continuation.

Decomposition:
- Package riscv_dbg_pkg holds:
  - dump_state_t enum (IDLE, HDR, LOAD, IDX, DATA, CSUM).
  - SYNC_BYTE default.
  - BYTES_PER_REG = 4.
- Natural sub-module: riscv_word_serializer.
  - Loads a 32-bit word and emits 4 bytes MSB-first under valid/ready.
  - Raises last on the 4th byte.
- The top FSM handles framing, indexing and the checksum.

Test Plan:
- Full dump, ready always high:
  - Stimulus: model regfile reg[i] = 32'h1000_0000 + i, then start.
  - Response: 162 bytes; first A5, then 00 10 00 00 00, 01 10 00 00 01, ..., last byte = XOR of bytes 2..161.
  - Response: done_out pulses once, 2 cycles after the last index… no — on the cycle after the checksum byte is accepted; busy_out low after.
- Backpressure:
  - Stimulus: byte_ready_in random at 30% duty.
  - Response: identical byte sequence to the ready-high case.
  - Response: byte_out stable across every stalled cycle.
- Partial range:
  - Stimulus: FIRST_REG=30, NUM_REGS=32, reg30=32'hDEADBEEF, reg31=32'h0.
  - Response: bytes are A5 1E DE AD BE EF 1F 00 00 00 00, then checksum 8'h1E^DE^AD^BE^EF^1F.
- Abort:
  - Stimulus: abort_in during the 3rd DATA byte of register 5, with valid && ready high in the same cycle.
  - Response: byte_valid_out = 0 next cycle and no done_out.
  - Response: a new start produces a full frame starting with A5.
- Reset mid-frame:
  - Stimulus: rst_n_in low asynchronously during IDX.
  - Response: byte_valid_out, busy_out and reg_debug_out = 0 before the next edge.
  - Response: start after release gives a normal full frame.
- Start while busy:
  - Stimulus: second start_in pulse at byte 40.
  - Response: ignored; exactly 162 bytes and one done_out pulse.
